// File: rtl/data_mem_responder.sv
// Handshaked data-memory responder: one request at a time, programmable wait states, held response.
// Optional DMEM_BYTE_EN adds the req_be port and per-byte write masking.
module data_mem_responder #(
  parameter int ADDR_W      = 6,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset_L,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
`ifdef DMEM_BYTE_EN
  input  logic [DATA_W/8-1:0] req_be,
`endif
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy
);

  localparam int NB = DATA_W / 8;
  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [3:0] WAIT_N = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic [3:0]        cnt_r;
  logic [3:0]        cnt_s;
  logic              cap_write_r;
  logic [ADDR_W-1:0] cap_addr_r;
  logic [DATA_W-1:0] cap_wdata_r;
  logic              rsp_valid_r;
  logic              rsp_write_r;
  logic [DATA_W-1:0] rsp_rdata_r;
  logic              accept_s;
  logic              commit_s;
  logic              cmt_write_s;
  logic [ADDR_W-1:0] cmt_addr_s;
  logic [DATA_W-1:0] cmt_wdata_s;
  logic [NB-1:0]     cmt_be_s;
  logic [DATA_W-1:0] mem [DEPTH];
`ifdef DMEM_BYTE_EN
  logic [NB-1:0]     cap_be_r;
`endif

  assign req_ready = Reset_L & (state_r == ST_IDLE);
  assign accept_s  = req_valid & req_ready;
  assign busy      = (state_r != ST_IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_write = rsp_write_r;
  assign rsp_rdata = rsp_rdata_r;

  // Next-state, wait counter and commit strobe
  always_comb begin
    state_s  = state_r;
    cnt_s    = cnt_r;
    commit_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          cnt_s = WAIT_N;
          if (WAIT_N == 4'd0) begin
            commit_s = 1'b1;
            state_s  = ST_RESP;
          end else begin
            state_s = ST_WAIT;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        cnt_s = cnt_r - 4'd1;
        if (cnt_r <= 4'd1) begin
          commit_s = 1'b1;
          state_s  = ST_RESP;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_RESP: begin
        if (rsp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: begin
        state_s = ST_IDLE;
        cnt_s   = 4'd0;
      end
    endcase
  end

  // Zero-wait commits happen on the accept edge, so they must use the live request
  always_comb begin
    if (state_r == ST_IDLE) begin
      cmt_write_s = req_write;
      cmt_addr_s  = req_addr;
      cmt_wdata_s = req_wdata;
`ifdef DMEM_BYTE_EN
      cmt_be_s    = req_be;
`else
      cmt_be_s    = {NB{1'b1}};
`endif
    end else begin
      cmt_write_s = cap_write_r;
      cmt_addr_s  = cap_addr_r;
      cmt_wdata_s = cap_wdata_r;
`ifdef DMEM_BYTE_EN
      cmt_be_s    = cap_be_r;
`else
      cmt_be_s    = {NB{1'b1}};
`endif
    end
  end

  // Control state, captured request and response registers
  always_ff @(posedge Clk or negedge Reset_L) begin
    if (!Reset_L) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 4'd0;
      cap_write_r <= 1'b0;
      cap_addr_r  <= {ADDR_W{1'b0}};
      cap_wdata_r <= {DATA_W{1'b0}};
`ifdef DMEM_BYTE_EN
      cap_be_r    <= {NB{1'b0}};
`endif
      rsp_valid_r <= 1'b0;
      rsp_write_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
    end else begin
      state_r     <= state_s;
      cnt_r       <= cnt_s;
      rsp_valid_r <= (state_s == ST_RESP);
      if (accept_s) begin
        cap_write_r <= req_write;
        cap_addr_r  <= req_addr;
        cap_wdata_r <= req_wdata;
`ifdef DMEM_BYTE_EN
        cap_be_r    <= req_be;
`endif
      end
      if (commit_s) begin
        rsp_write_r <= cmt_write_s;
        rsp_rdata_r <= cmt_write_s ? {DATA_W{1'b0}} : mem[cmt_addr_s];
      end
    end
  end

  // Storage array has no reset; only lanes with an enable are written
  always_ff @(posedge Clk) begin
    if (commit_s && cmt_write_s) begin
      for (int i = 0; i < NB; i++) begin
        if (cmt_be_s[i]) begin
          mem[cmt_addr_s][8*i +: 8] <= cmt_wdata_s[8*i +: 8];
        end
      end
    end
  end

  data_mem_responder_checker #(.DATA_W(DATA_W)) u_checker (
    .Clk       (Clk),
    .Reset_L   (Reset_L),
    .req_ready (req_ready),
    .busy      (busy),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_write (rsp_write),
    .rsp_rdata (rsp_rdata)
  );

endmodule

// Protocol properties of the responder's external handshakes.
module data_mem_responder_checker #(
  parameter int DATA_W = 32
) (
  input logic              Clk,
  input logic              Reset_L,
  input logic              req_ready,
  input logic              busy,
  input logic              rsp_valid,
  input logic              rsp_ready,
  input logic              rsp_write,
  input logic [DATA_W-1:0] rsp_rdata
);

  a_ready_idle: assert property (@(posedge Clk) disable iff (!Reset_L) req_ready |-> !busy);
  a_valid_busy: assert property (@(posedge Clk) disable iff (!Reset_L) rsp_valid |-> busy);
  a_rsp_hold: assert property (@(posedge Clk) disable iff (!Reset_L)
    (rsp_valid && !rsp_ready) |=> (rsp_valid && $stable(rsp_rdata) && $stable(rsp_write)));

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: directed table, reset/zero-wait sequences, randomized run vs. array model.
module tb_data_mem_responder;

`ifdef DMEM_BYTE_EN
  localparam bit BYTE_EN = 1'b1;
`else
  localparam bit BYTE_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        Reset_L;
  logic        req_valid, req_ready, req_write;
  logic [5:0]  req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        rsp_valid, rsp_ready, rsp_write, busy;
  logic [31:0] rsp_rdata;

  logic        z_req_valid, z_req_ready, z_req_write;
  logic [5:0]  z_req_addr;
  logic [31:0] z_req_wdata;
  logic        z_rsp_valid, z_rsp_write, z_busy;
  logic [31:0] z_rsp_rdata;
`ifdef DMEM_BYTE_EN
  logic [3:0]  z_req_be = 4'hF;
`endif

  int checks = 0;
  int errors = 0;
  logic [31:0] model_mem [64];

  always #5 clk = ~clk;

  data_mem_responder #(.ADDR_W(6), .DATA_W(32), .WAIT_CYCLES(2)) dut (
    .Clk(clk), .Reset_L(Reset_L),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef DMEM_BYTE_EN
    .req_be(req_be),
`endif
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_rdata(rsp_rdata), .busy(busy)
  );

  data_mem_responder #(.ADDR_W(6), .DATA_W(32), .WAIT_CYCLES(0)) dut0 (
    .Clk(clk), .Reset_L(Reset_L),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_write(z_req_write),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
`ifdef DMEM_BYTE_EN
    .req_be(z_req_be),
`endif
    .rsp_valid(z_rsp_valid), .rsp_ready(1'b1), .rsp_write(z_rsp_write),
    .rsp_rdata(z_rsp_rdata), .busy(z_busy)
  );

  typedef struct {
    bit          wr;
    logic [5:0]  addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          hold;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: plain array, byte lanes masked by be only when the feature is built in
  task automatic model_txn(input bit wr, input logic [5:0] a, input logic [31:0] d,
                           input logic [3:0] be, output logic [31:0] exp);
    logic [3:0] m;
    m = BYTE_EN ? be : 4'hF;
    if (wr) begin
      for (int j = 0; j < 4; j++)
        if (m[j]) model_mem[a][8*j +: 8] = d[8*j +: 8];
      exp = 32'h0;
    end else begin
      exp = model_mem[a];
    end
  endtask

  // One transaction on the WAIT_CYCLES=2 instance; garbage requests are offered while busy
  task automatic txn(input bit wr, input logic [5:0] a, input logic [31:0] d, input logic [3:0] be,
                     input int hold, output logic [31:0] rd, output bit rw, output int lat);
    int n;
    @(negedge clk);
    check("req_ready_idle", {63'h0, req_ready}, 64'h1);
    req_valid = 1'b1; req_write = wr; req_addr = a; req_wdata = d; req_be = be;
    rsp_ready = (hold == 0);
    @(posedge clk); #1;
    req_valid = 1'b1; req_write = 1'($urandom); req_addr = 6'($urandom);
    req_wdata = $urandom; req_be = 4'($urandom);
    lat = 1; n = 0;
    @(negedge clk);
    check("busy_after_accept", {62'h0, busy, req_ready}, 64'h2);
    while (!rsp_valid && n < 40) begin
      @(posedge clk); lat++; n++;
      @(negedge clk);
    end
    check("rsp_valid_seen", {63'h0, rsp_valid}, 64'h1);
    rd = rsp_rdata; rw = rsp_write;
    for (int k = 0; k < hold; k++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 6'($urandom); req_wdata = $urandom;
      @(posedge clk); @(negedge clk);
      check("hold_valid_ready", {62'h0, rsp_valid, req_ready}, 64'h2);
      check("hold_rdata", {32'h0, rsp_rdata}, {32'h0, rd});
      check("hold_write", {63'h0, rsp_write}, {63'h0, rw});
    end
    rsp_ready = 1'b1; req_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    check("done_valid_busy", {62'h0, rsp_valid, busy}, 64'h0);
    rsp_ready = 1'b0;
  endtask

  // Zero-wait transaction; starts and ends on a negedge so calls run back to back
  task automatic z_txn(input bit wr, input logic [5:0] a, input logic [31:0] d, output logic [31:0] rd);
    check("z_req_ready", {63'h0, z_req_ready}, 64'h1);
    z_req_valid = 1'b1; z_req_write = wr; z_req_addr = a; z_req_wdata = d;
    @(posedge clk); #1;
    z_req_valid = 1'b0;
    @(negedge clk);
    check("z_lat1_valid_busy_ready", {61'h0, z_rsp_valid, z_busy, z_req_ready}, 64'h6);
    check("z_rsp_write", {63'h0, z_rsp_write}, {63'h0, wr});
    rd = z_rsp_rdata;
    @(posedge clk); @(negedge clk);
    check("z_done_valid", {63'h0, z_rsp_valid}, 64'h0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        tbl[13];
    logic [31:0] rd, exp;
    bit          rw;
    int          lat;
    bit          wr;
    logic [5:0]  a;
    logic [31:0] d;
    logic [3:0]  be;

    tbl[0]  = '{1'b1, 6'd5,  32'hDEADBEEF, 4'hF, 0,  32'h0};
    tbl[1]  = '{1'b0, 6'd5,  32'h0,        4'hF, 0,  32'hDEADBEEF};
    tbl[2]  = '{1'b1, 6'd0,  32'h00000001, 4'hF, 0,  32'h0};
    tbl[3]  = '{1'b1, 6'd63, 32'hFFFF0000, 4'hF, 0,  32'h0};
    tbl[4]  = '{1'b0, 6'd0,  32'h0,        4'h0, 0,  32'h00000001};
    tbl[5]  = '{1'b0, 6'd63, 32'h0,        4'hF, 1,  32'hFFFF0000};
    tbl[6]  = '{1'b1, 6'd3,  32'h11223344, 4'hF, 0,  32'h0};
    tbl[7]  = '{1'b1, 6'd3,  32'hAABBCCDD, 4'h5, 0,  32'h0};
    tbl[8]  = '{1'b0, 6'd3,  32'h0,        4'hF, 0,  BYTE_EN ? 32'h11BB33DD : 32'hAABBCCDD};
    tbl[9]  = '{1'b0, 6'd5,  32'h0,        4'hF, 10, 32'hDEADBEEF};
    tbl[10] = '{1'b1, 6'd5,  32'h0,        4'h0, 3,  32'h0};
    tbl[11] = '{1'b1, 6'd7,  32'h0,        4'hF, 0,  32'h0};
    tbl[12] = '{1'b0, 6'd63, 32'h0,        4'hF, 2,  32'hFFFF0000};

    Reset_L = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = 6'd0;
    req_wdata = 32'h0; req_be = 4'hF; rsp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_write = 1'b0; z_req_addr = 6'd0; z_req_wdata = 32'h0;
    #2 Reset_L = 1'b0;
    #1;
    check("reset_outputs", {27'h0, rsp_valid, busy, rsp_write, req_ready, 1'b0, rsp_rdata}, 64'h0);
    repeat (2) @(negedge clk);
    Reset_L = 1'b1;

    for (int i = 0; i < 13; i++) begin
      txn(tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].be, tbl[i].hold, rd, rw, lat);
      check($sformatf("vec%0d_rdata", i), {32'h0, rd}, {32'h0, tbl[i].exp_rdata});
      check($sformatf("vec%0d_write", i), {63'h0, rw}, {63'h0, tbl[i].wr});
      check($sformatf("vec%0d_latency", i), 64'(lat), 64'd3);
    end
    check("vec5_back_read", {32'h0, rsp_rdata}, 64'hFFFF0000);

    // Reset during WAIT of a write: write must be dropped
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 6'd7; req_wdata = 32'h12345678; req_be = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    check("midwait_busy", {63'h0, busy}, 64'h1);
    Reset_L = 1'b0;
    #1;
    check("midwait_reset_outputs", {29'h0, rsp_valid, busy, req_ready, rsp_rdata}, 64'h0);
    @(negedge clk);
    Reset_L = 1'b1;
    #1;
    check("post_reset_ready", {63'h0, req_ready}, 64'h1);
    txn(1'b0, 6'd7, 32'h0, 4'hF, 0, rd, rw, lat);
    check("dropped_write_addr7", {32'h0, rd}, 64'h0);

    // Zero-wait instance: back-to-back at minimum spacing
    @(negedge clk);
    z_txn(1'b1, 6'd0,  32'hA5A5A5A5, rd);
    check("z_write0_rdata", {32'h0, rd}, 64'h0);
    z_txn(1'b1, 6'd63, 32'h5A5A5A5A, rd);
    z_txn(1'b0, 6'd0,  32'h0, rd);
    check("z_read0", {32'h0, rd}, 64'hA5A5A5A5);
    z_txn(1'b0, 6'd63, 32'h0, rd);
    check("z_read63", {32'h0, rd}, 64'h5A5A5A5A);

    // Randomized run against the array model
    for (int i = 0; i < 64; i++) begin
      d = $urandom;
      model_txn(1'b1, 6'(i), d, 4'hF, exp);
      txn(1'b1, 6'(i), d, 4'hF, 0, rd, rw, lat);
    end
    for (int i = 0; i < 150; i++) begin
      wr = 1'($urandom); a = 6'($urandom); d = $urandom; be = 4'($urandom);
      model_txn(wr, a, d, be, exp);
      txn(wr, a, d, be, int'($urandom_range(0, 2)), rd, rw, lat);
      check("rand_rdata", {32'h0, rd}, {32'h0, exp});
      check("rand_write", {63'h0, rw}, {63'h0, wr});
      check("rand_latency", 64'(lat), 64'd3);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
